lsu_param: RTL and testbench
============================

// Module: lsu_param
// PURPOSE
//  Parametrised per-thread load-store unit executing LDR/STR against data memory via valid/ready handshake.
//  Successor to the fixed 8-bit LSU: configurable data/address width, latched op, response timeout,
//  error flag, and a defined illegal-op case. One instance per thread; core sequences via core_state/lsu_state.
// PARAMETERS
//  DATA_BITS       8       width of rt, mem data, lsu_out
//  ADDR_BITS       8       width of memory address
//  TIMEOUT_CYCLES  64      max WAITING cycles before abort; 0 = timeout disabled
//  CORE_REQUEST    3'b011  core_state code that launches an access
//  CORE_UPDATE     3'b110  core_state code that retires DONE -> IDLE
// PORTS
//  clk                       in   1          clock, all state on rising edge
//  reset                     in   1          asynchronous, active-low reset
//  enable                    in   1          thread active; 0 = hold all state
//  core_state                in   3          core pipeline state
//  decoded_mem_read_enable   in   1          LDR decoded
//  decoded_mem_write_enable  in   1          STR decoded
//  rs                        in   DATA_BITS  address register
//  rt                        in   DATA_BITS  store data register
//  mem_read_valid            out  1          read request
//  mem_read_address          out  ADDR_BITS  read address
//  mem_read_ready            in   1          read data valid
//  mem_read_data             in   DATA_BITS  read data
//  mem_write_valid           out  1          write request
//  mem_write_address         out  ADDR_BITS  write address
//  mem_write_data            out  DATA_BITS  write data
//  mem_write_ready           in   1          write accepted
//  lsu_state                 out  2          IDLE=0 REQUESTING=1 WAITING=2 DONE=3
//  lsu_out                   out  DATA_BITS  last loaded value
//  lsu_error                 out  1          last op timed out or was illegal
// BEHAVIOUR
//  Reset (reset==0, async): lsu_state=IDLE; all valids, addresses, write data, lsu_out, lsu_error, timer = 0.
//  enable==0: state, outputs, timer hold unchanged (valids stay asserted if already high).
//  IDLE: if core_state==CORE_REQUEST and exactly one decoded enable set: latch op (RD/WR), clear lsu_error,
//   -> REQUESTING. Both enables set: lsu_error<=1, no request issued, -> DONE. Neither: stay IDLE.
//  REQUESTING (1 cycle): RD: mem_read_valid<=1, mem_read_address<=rs. WR: mem_write_valid<=1,
//   mem_write_address<=rs, mem_write_data<=rt. Timer<=0. -> WAITING. Decoded enables ignored after latch.
//  Address: ADDR_BITS<DATA_BITS truncates rs LSBs; ADDR_BITS>DATA_BITS zero-extends rs.
//  WAITING: sample only the latched op's ready; other channel's ready ignored; ready in REQUESTING ignored.
//   RD ready: mem_read_valid<=0, lsu_out<=mem_read_data, -> DONE. WR ready: mem_write_valid<=0, -> DONE.
//   No ready: timer++; if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: drop valid, lsu_error<=1,
//   lsu_out unchanged, -> DONE. Ready on the timeout cycle wins (normal completion, no error).
//  Latency: valid rises 2 cycles after CORE_REQUEST sampled in IDLE; DONE 1 cycle after ready sampled.
//  DONE: -> IDLE when core_state==CORE_UPDATE; otherwise hold. lsu_out and lsu_error persist until next op.
//  Only one valid ever high at a time; valid never drops before ready or timeout.
//  Timer width $clog2(TIMEOUT_CYCLES+1), min 1; never wraps (saturates path exits at limit).
// TESTING
//  LDR: rs=8'h2A, core_state=011, ready after 3 cyc with data 8'h5C -> read_valid/addr 2A, lsu_out=5C, DONE, err=0.
//  STR: rs=8'h10, rt=8'hA5, ready after 1 cyc -> write_valid, addr 10, data A5; DONE; core_state=110 -> IDLE.
//  Timeout: TIMEOUT_CYCLES=4, LDR, no ready -> valid high 4 WAITING cycles, then 0, lsu_error=1, lsu_out unchanged.
//  Illegal: both decoded enables in CORE_REQUEST -> no valid ever, DONE, lsu_error=1; next legal op clears it.
//  Reset mid-WAITING: drop reset async while read_valid=1 -> valid=0, lsu_state=IDLE immediately, before clk edge.
//  enable=0 for 5 cycles in WAITING with ready=1 -> state/valid held, timer frozen; enable=1 -> completes next edge.

Source files
------------

// File: rtl/lsu_param.sv
// Per-thread load-store unit: one LDR/STR per core request over valid/ready
// memory channels, with response timeout and illegal-op error reporting.
module lsu_param #(
   parameter int          DATA_BITS      = 8,
   parameter int          ADDR_BITS      = 8,
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [2:0]  CORE_REQUEST   = 3'b011,
   parameter logic [2:0]  CORE_UPDATE    = 3'b110
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_mem_read_enable,
   input  logic                 decoded_mem_write_enable,
   input  logic [DATA_BITS-1:0] rs,
   input  logic [DATA_BITS-1:0] rt,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_write_ready,
   output logic [1:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out,
   output logic                 lsu_error
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int TW =
      (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TW-1:0] TLIM =
      TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [ADDR_BITS-1:0] addr;
   logic [TW-1:0]        timer;
   logic                 op_wr;
   logic                 rdy;
   logic                 rd_req;
   logic                 wr_req;

   generate
      if (ADDR_BITS <= DATA_BITS) begin : g_trunc
         assign addr = rs[ADDR_BITS-1:0];
      end else begin : g_zext
         assign addr = {{(ADDR_BITS - DATA_BITS){1'b0}}, rs};
      end
   endgenerate

   // Only the latched channel's ready can complete the access.
   assign rdy    = op_wr ? mem_write_ready : mem_read_ready;
   assign rd_req = decoded_mem_read_enable;
   assign wr_req = decoded_mem_write_enable;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lsu_state         <= S_IDLE;
         mem_read_valid    <= 1'b0;
         mem_read_address  <= '0;
         mem_write_valid   <= 1'b0;
         mem_write_address <= '0;
         mem_write_data    <= '0;
         lsu_out           <= '0;
         lsu_error         <= 1'b0;
         timer             <= '0;
         op_wr             <= 1'b0;
      end else if (enable) begin
         unique case (lsu_state)
            S_IDLE: begin
               if (core_state == CORE_REQUEST) begin
                  if (rd_req && wr_req) begin
                     lsu_error <= 1'b1;
                     lsu_state <= S_DONE;
                  end else if (rd_req || wr_req) begin
                     op_wr     <= wr_req;
                     lsu_error <= 1'b0;
                     lsu_state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (op_wr) begin
                  mem_write_valid   <= 1'b1;
                  mem_write_address <= addr;
                  mem_write_data    <= rt;
               end else begin
                  mem_read_valid   <= 1'b1;
                  mem_read_address <= addr;
               end
               timer     <= '0;
               lsu_state <= S_WAIT;
            end
            S_WAIT: begin
               if (rdy) begin
                  if (op_wr) begin
                     mem_write_valid <= 1'b0;
                  end else begin
                     mem_read_valid <= 1'b0;
                     lsu_out        <= mem_read_data;
                  end
                  lsu_state <= S_DONE;
               end else begin
                  if (timer != '1) timer <= timer + 1'b1;
                  if (TO_EN && timer == TLIM) begin
                     mem_read_valid  <= 1'b0;
                     mem_write_valid <= 1'b0;
                     lsu_error       <= 1'b1;
                     lsu_state       <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (core_state == CORE_UPDATE) lsu_state <= S_IDLE;
            end
            default: lsu_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_param.sv
// Directed bench for lsu_param with a cycle-level reference model
// and per-cycle output comparison.
module tb_lsu_param;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b1;
   logic [2:0] core_state = 3'd0;
   logic       rd_en = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] rs = 8'h00;
   logic [7:0] rt = 8'h00;
   logic       mem_read_valid;
   logic [7:0] mem_read_address;
   logic       mem_read_ready = 1'b0;
   logic [7:0] mem_read_data = 8'h00;
   logic       mem_write_valid;
   logic [7:0] mem_write_address;
   logic [7:0] mem_write_data;
   logic       mem_write_ready = 1'b0;
   logic [1:0] lsu_state;
   logic [7:0] lsu_out;
   logic       lsu_error;

   int n_chk = 0;
   int n_fail = 0;
   bit cmp_on = 1'b0;

   always #5 clk = ~clk;

   lsu_param #(
      .DATA_BITS(8), .ADDR_BITS(8), .TIMEOUT_CYCLES(4),
      .CORE_REQUEST(3'b011), .CORE_UPDATE(3'b110)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .core_state(core_state),
      .decoded_mem_read_enable(rd_en),
      .decoded_mem_write_enable(wr_en),
      .rs(rs),
      .rt(rt),
      .mem_read_valid(mem_read_valid),
      .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready),
      .mem_read_data(mem_read_data),
      .mem_write_valid(mem_write_valid),
      .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data),
      .mem_write_ready(mem_write_ready),
      .lsu_state(lsu_state),
      .lsu_out(lsu_out),
      .lsu_error(lsu_error)
   );

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   // Reference model: one access = phases idle/request/wait/done
   int         m_st;
   bit         m_wr;
   int         m_waited;
   logic       m_rv, m_wv, m_err;
   logic [7:0] m_ra, m_wa, m_wd, m_out;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_st = 0; m_wr = 0; m_waited = 0;
         m_rv = 0; m_wv = 0; m_err = 0;
         m_ra = 0; m_wa = 0; m_wd = 0; m_out = 0;
      end else if (enable) begin
         case (m_st)
            0: if (core_state == 3'b011) begin
               if (rd_en && wr_en) begin
                  m_err = 1; m_st = 3;
               end else if (rd_en != wr_en) begin
                  m_wr = wr_en; m_err = 0; m_st = 1;
               end
            end
            1: begin
               if (m_wr) begin
                  m_wv = 1; m_wa = rs; m_wd = rt;
               end else begin
                  m_rv = 1; m_ra = rs;
               end
               m_waited = 0; m_st = 2;
            end
            2: begin
               if (m_wr ? mem_write_ready : mem_read_ready) begin
                  if (!m_wr) m_out = mem_read_data;
                  m_rv = 0; m_wv = 0; m_st = 3;
               end else begin
                  m_waited++;
                  if (m_waited == 4) begin
                     m_rv = 0; m_wv = 0; m_err = 1; m_st = 3;
                  end
               end
            end
            default: if (core_state == 3'b110) m_st = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("state", 32'(lsu_state), 32'(m_st));
         chk("rd_valid", 32'(mem_read_valid), 32'(m_rv));
         chk("rd_addr", 32'(mem_read_address), 32'(m_ra));
         chk("wr_valid", 32'(mem_write_valid), 32'(m_wv));
         chk("wr_addr", 32'(mem_write_address), 32'(m_wa));
         chk("wr_data", 32'(mem_write_data), 32'(m_wd));
         chk("lsu_out", 32'(lsu_out), 32'(m_out));
         chk("lsu_error", 32'(lsu_error), 32'(m_err));
         chk("one_valid", 32'(mem_read_valid & mem_write_valid), 0);
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic launch(bit r, bit w, logic [7:0] a, logic [7:0] d);
      rd_en = r; wr_en = w; rs = a; rt = d; core_state = 3'b011;
      cyc(1);
      core_state = 3'b000; rd_en = 0; wr_en = 0;
   endtask

   task automatic retire();
      core_state = 3'b110;
      cyc(1);
      core_state = 3'b000;
   endtask

   initial begin
      cyc(2);
      cmp_on = 1;
      chk("rst_state", 32'(lsu_state), 0);
      chk("rst_rv", 32'(mem_read_valid), 0);
      chk("rst_out", 32'(lsu_out), 0);
      reset = 1;
      cyc(2);
      chk("idle_hold", 32'(lsu_state), 0);

      // LDR 2A -> 5C after 3 waiting cycles
      launch(1, 0, 8'h2A, 8'h00);
      chk("ldr_req", 32'(lsu_state), 1);
      chk("ldr_req_rv", 32'(mem_read_valid), 0);
      cyc(1);
      chk("ldr_rv", 32'(mem_read_valid), 1);
      chk("ldr_addr", 32'(mem_read_address), 32'h2A);
      cyc(2);
      mem_read_ready = 1; mem_read_data = 8'h5C;
      cyc(1);
      mem_read_ready = 0;
      chk("ldr_done", 32'(lsu_state), 3);
      chk("ldr_out", 32'(lsu_out), 32'h5C);
      chk("ldr_err", 32'(lsu_error), 0);
      cyc(2);
      chk("done_hold", 32'(lsu_state), 3);
      retire();
      chk("ldr_idle", 32'(lsu_state), 0);

      // STR 10<-A5, ready already high during request, read ready ignored
      mem_read_data = 8'hEE;
      launch(0, 1, 8'h10, 8'hA5);
      mem_write_ready = 1; mem_read_ready = 1;
      cyc(1);
      chk("str_wv", 32'(mem_write_valid), 1);
      chk("str_addr", 32'(mem_write_address), 32'h10);
      chk("str_data", 32'(mem_write_data), 32'hA5);
      cyc(1);
      mem_write_ready = 0; mem_read_ready = 0;
      chk("str_done", 32'(lsu_state), 3);
      chk("str_out", 32'(lsu_out), 32'h5C);
      retire();
      chk("str_idle", 32'(lsu_state), 0);

      // Timeout after 4 waiting cycles, write ready ignored
      launch(1, 0, 8'h33, 8'h00);
      cyc(1);
      mem_write_ready = 1;
      cyc(3);
      chk("to_wait", 32'(lsu_state), 2);
      chk("to_rv", 32'(mem_read_valid), 1);
      cyc(1);
      mem_write_ready = 0;
      chk("to_done", 32'(lsu_state), 3);
      chk("to_rv_low", 32'(mem_read_valid), 0);
      chk("to_err", 32'(lsu_error), 1);
      chk("to_out", 32'(lsu_out), 32'h5C);
      retire();

      // Ready on the timeout cycle completes normally
      launch(1, 0, 8'h44, 8'h00);
      cyc(4);
      mem_read_ready = 1; mem_read_data = 8'h77;
      cyc(1);
      mem_read_ready = 0;
      chk("edge_err", 32'(lsu_error), 0);
      chk("edge_out", 32'(lsu_out), 32'h77);
      retire();

      // Illegal op, then a legal op clears the error
      launch(1, 1, 8'h55, 8'h66);
      chk("ill_state", 32'(lsu_state), 3);
      chk("ill_err", 32'(lsu_error), 1);
      cyc(2);
      chk("ill_wv", 32'(mem_write_valid), 0);
      retire();
      launch(0, 1, 8'h55, 8'h66);
      chk("clr_err", 32'(lsu_error), 0);
      cyc(1);
      mem_write_ready = 1;
      cyc(1);
      mem_write_ready = 0;
      chk("clr_done", 32'(lsu_state), 3);
      retire();

      // Enable low in WAITING with ready high
      launch(1, 0, 8'h2A, 8'h00);
      cyc(1);
      enable = 0; mem_read_ready = 1; mem_read_data = 8'h99;
      cyc(5);
      chk("en_state", 32'(lsu_state), 2);
      chk("en_rv", 32'(mem_read_valid), 1);
      chk("en_out", 32'(lsu_out), 32'h77);
      enable = 1;
      cyc(1);
      mem_read_ready = 0;
      chk("en_done", 32'(lsu_out), 32'h99);
      retire();

      // Timer frozen while disabled
      launch(1, 0, 8'h12, 8'h00);
      cyc(3);
      enable = 0;
      cyc(5);
      enable = 1;
      cyc(1);
      chk("frz_wait", 32'(lsu_state), 2);
      cyc(1);
      chk("frz_to", 32'(lsu_error), 1);
      enable = 0; core_state = 3'b110;
      cyc(2);
      chk("frz_done", 32'(lsu_state), 3);
      enable = 1;
      cyc(1);
      core_state = 3'b000;
      chk("frz_idle", 32'(lsu_state), 0);

      // Asynchronous reset in WAITING
      launch(1, 0, 8'h2A, 8'h00);
      cyc(1);
      chk("ar_rv", 32'(mem_read_valid), 1);
      #2 reset = 0;
      #1;
      chk("ar_rv_low", 32'(mem_read_valid), 0);
      chk("ar_state", 32'(lsu_state), 0);
      cyc(1);
      reset = 1;
      cyc(1);
      chk("ar_out", 32'(lsu_out), 0);

      cmp_on = 0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
